// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_pkg
// Description : Shared address map, timer-compare reset value and the
//               region-decode enum for the memory bus controller.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

  localparam logic [31:0] c_addr_led    = 32'hFFFF_0000;
  localparam logic [31:0] c_addr_sw     = 32'hFFFF_0004;
  localparam logic [31:0] c_addr_tcount = 32'hFFFF_0008;
  localparam logic [31:0] c_addr_tcmp   = 32'hFFFF_000C;
  localparam logic [31:0] c_addr_tstat  = 32'hFFFF_0010;
  localparam logic [31:0] c_tcmp_rst    = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    REG_NONE   = 3'd0,
    REG_RAM    = 3'd1,
    REG_LED    = 3'd2,
    REG_SW     = 3'd3,
    REG_TCOUNT = 3'd4,
    REG_TCMP   = 3'd5,
    REG_TSTAT  = 3'd6
  } region_e;

  // RAM hit is resolved by the caller, which knows the RAM depth.
  function automatic region_e decode(input logic [31:0] addr, input logic ram_hit);
    if (ram_hit) return REG_RAM;
    case (addr)
      c_addr_led:    return REG_LED;
      c_addr_sw:     return REG_SW;
      c_addr_tcount: return REG_TCOUNT;
      c_addr_tcmp:   return REG_TCMP;
      c_addr_tstat:  return REG_TSTAT;
      default:       return REG_NONE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_ram.sv
`default_nettype none
// ============================================================================
// Module      : bus_ram
// Description : Word-wide RAM, asynchronous read and synchronous write.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_ram #(
  parameter  int RAM_WORDS = 1024,
  localparam int AW        = $clog2(RAM_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  // Contents are deliberately not reset.
  logic [31:0] r_mem [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (we) r_mem[addr] <= wdata;
  end

  assign rdata = r_mem[addr];

endmodule
`default_nettype wire

// File: rtl/mem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_ctrl
// Description : Zero-wait-state CPU bus slave: RAM, LED/switch ports and a
//               prescaled timer with compare-match status.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_ctrl #(
  parameter int RAM_WORDS = 1024,
  parameter int CLK_DIV   = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        mem_read,
  input  logic        mem_write,
  inout  wire  [31:0] bus,
  input  logic [15:0] sw,
  output logic [15:0] led
);
  import bus_pkg::*;

  localparam int            AW         = $clog2(RAM_WORDS);
  localparam int            PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] c_pre_last = PW'(CLK_DIV - 1);

  logic [15:0]   r_led;
  logic [15:0]   r_sw1, r_sw2;
  logic [31:0]   r_tcount, r_tcmp;
  logic [PW-1:0] r_pre;
  logic          r_match;

  logic          w_ram_hit;
  region_e       w_region;
  logic          w_wr, w_tick, w_tc_wr, w_match_set, w_match_clr;
  logic [31:0]   w_tc_next, w_ram_rdata, w_rdata;
  logic          w_unused;

  assign w_unused  = &{1'b0, addr[1:0]};
  assign w_ram_hit = (addr[31:AW+2] == '0);
  assign w_region  = decode(addr, w_ram_hit);

  // A strobe that overlaps reset must not reach the (unreset) RAM either.
  assign w_wr        = mem_write & ~rst;
  assign w_tick      = (r_pre == c_pre_last);
  assign w_tc_wr     = w_wr && (w_region == REG_TCOUNT);
  assign w_tc_next   = r_tcount + 32'd1;
  assign w_match_set = w_tick && !w_tc_wr && (w_tc_next == r_tcmp);
  assign w_match_clr = w_wr && (w_region == REG_TSTAT) && bus[0];

  bus_ram #(.RAM_WORDS(RAM_WORDS)) u_ram (
    .clk   (clk),
    .we    (w_wr && (w_region == REG_RAM)),
    .addr  (addr[AW+1:2]),
    .wdata (bus),
    .rdata (w_ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_led    <= '0;
      r_sw1    <= '0;
      r_sw2    <= '0;
      r_tcount <= '0;
      r_tcmp   <= c_tcmp_rst;
      r_pre    <= '0;
      r_match  <= 1'b0;
    end else begin
      r_sw1 <= sw;
      r_sw2 <= r_sw1;
      if (w_wr && (w_region == REG_LED))  r_led  <= bus[15:0];
      if (w_wr && (w_region == REG_TCMP)) r_tcmp <= bus;
      // A TCOUNT write restarts the prescale period and masks any tick.
      if (w_tc_wr) begin
        r_tcount <= bus;
        r_pre    <= '0;
      end else if (w_tick) begin
        r_tcount <= w_tc_next;
        r_pre    <= '0;
      end else begin
        r_pre <= r_pre + 1'b1;
      end
      if (w_match_set)      r_match <= 1'b1;
      else if (w_match_clr) r_match <= 1'b0;
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_region)
      REG_RAM:    w_rdata = w_ram_rdata;
      REG_LED:    w_rdata = {16'h0, r_led};
      REG_SW:     w_rdata = {16'h0, r_sw2};
      REG_TCOUNT: w_rdata = r_tcount;
      REG_TCMP:   w_rdata = r_tcmp;
      REG_TSTAT:  w_rdata = {31'h0, r_match};
      default:    w_rdata = '0;
    endcase
  end

  assign bus = (mem_read && !mem_write && !rst) ? w_rdata : 'z;
  assign led = r_led;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_ctrl
// Description : Self-checking bench: directed bus transactions, a cycle-level
//               reference model compared every negedge, plus literal pins.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_ctrl;

  localparam int NW  = 256;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = '0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [31:0] tb_drv = '0;
  logic        tb_oe = 1'b0;
  logic [15:0] sw = '0;
  wire  [31:0] bus;
  logic [15:0] led;

  int n_pass = 0;
  int n_total = 0;

  assign bus = tb_oe ? tb_drv : 32'hzzzz_zzzz;

  mem_bus_ctrl #(.RAM_WORDS(NW), .CLK_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .addr(addr), .mem_read(mem_read),
    .mem_write(mem_write), .bus(bus), .sw(sw), .led(led)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0] m_ram [0:NW-1];
  logic [15:0] m_led = '0, m_s1 = '0, m_s2 = '0;
  logic [31:0] m_tcount = '0, m_tcmp = 32'hFFFF_FFFF;
  int          m_pre = 0;
  logic        m_match = 1'b0;

  initial for (int i = 0; i < NW; i++) m_ram[i] = '0;

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a < NW * 4) return m_ram[a / 4];
    case (a)
      32'hFFFF_0000: return {16'h0, m_led};
      32'hFFFF_0004: return {16'h0, m_s2};
      32'hFFFF_0008: return m_tcount;
      32'hFFFF_000C: return m_tcmp;
      32'hFFFF_0010: return {31'h0, m_match};
      default:       return 32'h0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin : model
    logic        tick, tcw;
    logic [31:0] nt;
    if (rst) begin
      m_led <= '0; m_s1 <= '0; m_s2 <= '0;
      m_tcount <= '0; m_tcmp <= 32'hFFFF_FFFF; m_pre <= 0; m_match <= 1'b0;
    end else begin
      m_s1 <= sw;
      m_s2 <= m_s1;
      tick = (m_pre == DIV - 1);
      tcw  = mem_write && addr == 32'hFFFF_0008;
      nt   = m_tcount + 1;
      if (tcw) begin
        m_tcount <= bus; m_pre <= 0;
      end else begin
        m_pre <= tick ? 0 : m_pre + 1;
        if (tick) m_tcount <= nt;
      end
      if (tick && !tcw && nt == m_tcmp) m_match <= 1'b1;
      else if (mem_write && addr == 32'hFFFF_0010 && bus[0]) m_match <= 1'b0;
      if (mem_write) begin
        if (addr < NW * 4) m_ram[addr / 4] <= bus;
        else if (addr == 32'hFFFF_0000) m_led <= bus[15:0];
        else if (addr == 32'hFFFF_000C) m_tcmp <= bus;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  always @(negedge clk) begin
    chk("led_model", {16'h0, led}, {16'h0, m_led});
    if (mem_read && !mem_write && !rst) chk("bus_model", bus, m_read(addr));
    if (tb_oe) chk("bus_cpu_drive", bus, tb_drv);
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; tb_drv = d; tb_oe = 1'b1; mem_write = 1'b1;
    cyc();
    mem_write = 1'b0; tb_oe = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr = a; mem_read = 1'b1;
    @(negedge clk); d = bus;
    cyc();
    mem_read = 1'b0;
  endtask

  task automatic rdchk(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    chk(name, d, exp);
  endtask

  initial begin
    logic [31:0] d;
    #1 rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    rdchk("rst_tcmp",   32'hFFFF_000C, 32'hFFFF_FFFF);
    chk("rst_led", {16'h0, led}, 32'h0);
    rdchk("rst_tstat",  32'hFFFF_0010, 32'h0);
    rdchk("rst_sw",     32'hFFFF_0004, 32'h0);

    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rdchk("ram_byte_alias", 32'h0000_0013, 32'hDEAD_BEEF);
    wr(32'h0000_0000, 32'h0000_0011);
    wr(32'h0000_0400, 32'h0000_0099);
    rdchk("unmapped_wr_ignored", 32'h0000_0000, 32'h0000_0011);
    rdchk("unmapped_ram_rd",     32'h0000_0400, 32'h0);
    rdchk("unmapped_io_rd",      32'hFFFF_0014, 32'h0);

    // Read+write collision: the write must win and the block stays off the bus.
    wr(32'hFFFF_0000, 32'h0000_FFFF);
    addr = 32'hFFFF_0000; tb_drv = 32'h0000_1234; tb_oe = 1'b1;
    mem_write = 1'b1; mem_read = 1'b1;
    @(negedge clk);
    chk("rw_collision_bus", bus, 32'h0000_1234);
    cyc();
    mem_write = 1'b0; mem_read = 1'b0; tb_oe = 1'b0;
    @(negedge clk);
    chk("rw_collision_led", {16'h0, led}, 32'h0000_1234);
    cyc();

    sw = 16'hA5A5;
    cyc();
    rdchk("sw_cycle1", 32'hFFFF_0004, 32'h0);
    rdchk("sw_cycle2", 32'hFFFF_0004, 32'h0000_A5A5);
    wr(32'hFFFF_0004, 32'h0000_1111);
    rdchk("sw_wr_ignored", 32'hFFFF_0004, 32'h0000_A5A5);

    wr(32'hFFFF_000C, 32'h3);
    wr(32'hFFFF_0008, 32'h0);
    for (int j = 0; j <= 12; j++) begin
      rd(32'hFFFF_0010, d);
      if (j == 11) chk("match_not_yet", d, 32'h0);
      if (j == 12) chk("match_at_12", d, 32'h1);
    end

    wr(32'hFFFF_0008, 32'hFFFF_FFFF);
    for (int j = 0; j <= 4; j++) begin
      rd(32'hFFFF_0008, d);
      if (j == 3) chk("tcount_pre_wrap", d, 32'hFFFF_FFFF);
      if (j == 4) chk("tcount_wrap", d, 32'h0);
    end

    wr(32'hFFFF_0008, 32'h0000_0100);
    wr(32'hFFFF_000C, 32'h2);
    wr(32'hFFFF_0010, 32'h0);
    rdchk("w0_no_clear", 32'hFFFF_0010, 32'h1);
    wr(32'hFFFF_0010, 32'h1);
    rdchk("w1c_clear", 32'hFFFF_0010, 32'h0);
    wr(32'hFFFF_0008, 32'h2);
    rdchk("tcount_eq_wr_no_set", 32'hFFFF_0010, 32'h0);
    wr(32'hFFFF_0008, 32'h0);
    repeat (7) cyc();
    wr(32'hFFFF_0010, 32'h1);
    rdchk("set_beats_clear", 32'hFFFF_0010, 32'h1);

    wr(32'h0000_0020, 32'h0000_0055);
    wr(32'hFFFF_0000, 32'h0000_BEEF);
    rst = 1'b1;
    addr = 32'h0000_0020; tb_drv = 32'h0000_0066; tb_oe = 1'b1; mem_write = 1'b1;
    @(negedge clk);
    chk("rst_led_immediate", {16'h0, led}, 32'h0);
    cyc();
    mem_write = 1'b0; tb_oe = 1'b0;
    cyc();
    rst = 1'b0;
    rdchk("rst2_tcmp",     32'hFFFF_000C, 32'hFFFF_FFFF);
    rdchk("rst2_ram_keep", 32'h0000_0010, 32'hDEAD_BEEF);
    rdchk("rst2_wr_ignored", 32'h0000_0020, 32'h0000_0055);
    rdchk("rst2_led",      32'hFFFF_0000, 32'h0);
    rdchk("rst2_sw",       32'hFFFF_0004, 32'h0000_A5A5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
